// File: rtl/sig_dump.sv
// sig_dump: walks a word-address range of the data RAM and streams each word out over valid/ready.
//   clk, rst              clock, asynchronous active-high reset
//   start                 begin a dump (sampled only while idle)
//   begin_addr, end_addr  first and one-past-last word address, sampled with start
//   ram_re, ram_addr      RAM read port request (data returns one cycle later)
//   ram_rdata             RAM read data
//   out_valid, out_data   stream word, held stable until out_ready
//   out_last              marks the final word of the range
//   out_ready             downstream accept
//   busy, done            dump in progress, one-cycle completion pulse
module sig_dump #(
    parameter int ADDR_WIDTH = 10
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  start,
    input  logic [ADDR_WIDTH-1:0] begin_addr,
    input  logic [ADDR_WIDTH-1:0] end_addr,
    output logic                  ram_re,
    output logic [ADDR_WIDTH-1:0] ram_addr,
    input  logic [31:0]           ram_rdata,
    output logic                  out_valid,
    output logic [31:0]           out_data,
    output logic                  out_last,
    input  logic                  out_ready,
    output logic                  busy,
    output logic                  done
);
    typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;
    state_t state_q, state_d;
    logic [ADDR_WIDTH-1:0] rd_ptr_q, rd_ptr_d, remaining_q, remaining_d;
    logic [ADDR_WIDTH-1:0] issued_q, issued_d, popped_q, popped_d;
    logic inflight_q;
    logic [31:0] fifo_q [2];
    logic wr_q, rd_q;
    logic [1:0] cnt_q;
    logic pop, credit;
    assign out_valid = cnt_q != 2'd0;
    assign pop       = out_valid && out_ready;
    // Every issued read needs a guaranteed buffer slot; a pop this cycle frees one.
    assign credit    = (cnt_q + 2'(inflight_q)) <= (pop ? 2'd2 : 2'd1);
    assign ram_re    = state_q == RUN && issued_q < remaining_q && credit;
    assign ram_addr  = rd_ptr_q;
    assign out_data  = out_valid ? fifo_q[rd_q] : 32'd0;
    // Head word number equals the count of words already popped.
    assign out_last  = out_valid && popped_q == remaining_q - ADDR_WIDTH'(1);
    assign busy      = state_q != IDLE;
    assign done      = state_q == DONE;
    always_comb begin
        state_d     = state_q;
        rd_ptr_d    = rd_ptr_q;
        remaining_d = remaining_q;
        issued_d    = issued_q;
        popped_d    = popped_q;
        case (state_q)
            IDLE: if (start) begin
                rd_ptr_d    = begin_addr;
                remaining_d = end_addr - begin_addr;
                issued_d    = '0;
                popped_d    = '0;
                state_d     = end_addr == begin_addr ? DONE : RUN;
            end
            RUN: begin
                rd_ptr_d = ram_re ? rd_ptr_q + ADDR_WIDTH'(1) : rd_ptr_q;
                issued_d = ram_re ? issued_q + ADDR_WIDTH'(1) : issued_q;
                popped_d = pop ? popped_q + ADDR_WIDTH'(1) : popped_q;
                state_d  = pop && out_last ? DONE : RUN;
            end
            default: state_d = IDLE;
        endcase
    end
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q     <= IDLE;
            rd_ptr_q    <= '0;
            remaining_q <= '0;
            issued_q    <= '0;
            popped_q    <= '0;
            inflight_q  <= 1'b0;
            wr_q        <= 1'b0;
            rd_q        <= 1'b0;
            cnt_q       <= 2'd0;
        end else begin
            state_q     <= state_d;
            rd_ptr_q    <= rd_ptr_d;
            remaining_q <= remaining_d;
            issued_q    <= issued_d;
            popped_q    <= popped_d;
            inflight_q  <= ram_re;
            wr_q        <= wr_q ^ inflight_q;
            rd_q        <= rd_q ^ pop;
            cnt_q       <= cnt_q + 2'(inflight_q) - 2'(pop);
        end
    end
    // Storage needs no reset: out_data is gated by out_valid.
    always_ff @(posedge clk) begin
        if (inflight_q) fifo_q[wr_q] <= ram_rdata;
    end
endmodule

// File: tb/tb_sig_dump.sv
// tb_sig_dump: directed, table-driven bench for sig_dump against a 1-cycle RAM model.
module tb_sig_dump;
    logic        clk = 1'b0;
    logic        rst, start, out_ready;
    logic [9:0]  begin_addr, end_addr, ram_addr;
    logic        ram_re, out_valid, out_last, busy, done;
    logic [31:0] ram_rdata, out_data;
    logic [31:0] mem [1024];
    int nvec = 0, nfail = 0;

    typedef struct {
        logic [9:0] b;
        logic [9:0] e;
        int         mode;
        int         n;
        bit         restart;
    } vec_t;
    vec_t vecs [7];
    bit pat [6] = '{1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 1'b1};

    sig_dump #(.ADDR_WIDTH(10)) dut (
        .clk(clk), .rst(rst), .start(start), .begin_addr(begin_addr), .end_addr(end_addr),
        .ram_re(ram_re), .ram_addr(ram_addr), .ram_rdata(ram_rdata),
        .out_valid(out_valid), .out_data(out_data), .out_last(out_last), .out_ready(out_ready),
        .busy(busy), .done(done)
    );

    always #5 clk = ~clk;

    always @(posedge clk) if (ram_re) ram_rdata <= mem[ram_addr];

    task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
        nvec++;
        if (act !== exp) begin
            nfail++;
            $display("FAIL %s: got %h expected %h", nm, act, exp);
        end
    endtask

    task automatic check_idle_outputs(input string nm);
        check({nm, " ram_re"}, 32'(ram_re), 0);
        check({nm, " ram_addr"}, 32'(ram_addr), 0);
        check({nm, " out_valid"}, 32'(out_valid), 0);
        check({nm, " out_data"}, out_data, 0);
        check({nm, " out_last"}, 32'(out_last), 0);
        check({nm, " busy"}, 32'(busy), 0);
        check({nm, " done"}, 32'(done), 0);
    endtask

    task automatic dump(input vec_t v);
        logic [31:0] words [64];
        bit lasts [64];
        int nw = 0, nre = 0, nbusy = 0, ndone = 0, done_c = 0, first_v = 0;
        int outstanding = 0, viol = 0, post = 0, c = 0, pop;
        begin_addr = v.b;
        end_addr   = v.e;
        start      = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
        while (c < 300 && post < 3) begin
            c++;
            if (c > 1) begin @(posedge clk); #1; end
            out_ready = v.mode == 0 ? 1'b1 : pat[c % 6];
            if (v.restart) begin
                start      = c == 4 || c == 19;
                begin_addr = 10'd200;
                end_addr   = 10'd210;
            end
            #1;
            pop = int'(out_valid && out_ready);
            if (ram_re && outstanding >= 2 && pop == 0) viol++;
            if (ram_re) nre++;
            if (out_valid && first_v == 0) first_v = c;
            if (pop != 0 && nw < 64) begin
                words[nw] = out_data;
                lasts[nw] = out_last;
                nw++;
            end
            outstanding += int'(ram_re) - pop;
            if (busy) nbusy++;
            if (done) begin
                ndone++;
                if (done_c == 0) done_c = c;
            end
            if (done_c != 0) post++;
        end
        start = 1'b0;
        if (post < 3) $display("FAIL timeout: dump %0d..%0d never completed", v.b, v.e);
        check("word count", 32'(nw), 32'(v.n));
        for (int k = 0; k < nw && k < v.n; k++) begin
            check("word data", words[k], 32'hA500_0000 + 32'((int'(v.b) + k) % 1024));
            check("word last", 32'(lasts[k]), 32'(k == v.n - 1));
        end
        check("done pulses", 32'(ndone), 1);
        check("ram_re count", 32'(nre), 32'(v.n));
        check("credit violations", 32'(viol), 0);
        check("busy cycles", 32'(nbusy), 32'(done_c));
        if (v.mode == 0) begin
            check("done cycle", 32'(done_c), v.n == 0 ? 1 : 32'(v.n + 3));
            check("first valid cycle", 32'(first_v), v.n == 0 ? 0 : 3);
        end
    endtask

    initial begin
        for (int i = 0; i < 1024; i++) mem[i] = 32'hA500_0000 + 32'(i);
        vecs[0] = '{10'd4,    10'd8,   0, 4,  1'b0};
        vecs[1] = '{10'd4,    10'd8,   1, 4,  1'b0};
        vecs[2] = '{10'd1022, 10'd2,   0, 4,  1'b0};
        vecs[3] = '{10'd5,    10'd5,   0, 0,  1'b0};
        vecs[4] = '{10'd100,  10'd116, 0, 16, 1'b1};
        vecs[5] = '{10'd10,   10'd13,  1, 3,  1'b0};
        vecs[6] = '{10'd1023, 10'd0,   1, 1,  1'b0};
        rst = 1'b1; start = 1'b0; out_ready = 1'b0; begin_addr = '0; end_addr = '0;
        repeat (2) @(posedge clk);
        #1;
        check_idle_outputs("reset");
        rst = 1'b0;
        // Reset mid-dump with one word buffered and downstream stalled.
        begin_addr = 10'd4; end_addr = 10'd8; start = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
        check("mid ram_re", 32'(ram_re), 1);
        check("mid ram_addr", 32'(ram_addr), 4);
        repeat (2) begin @(posedge clk); #1; end
        check("mid valid", 32'(out_valid), 1);
        check("mid data", out_data, 32'hA500_0004);
        rst = 1'b1;
        #1;
        check_idle_outputs("async reset");
        @(posedge clk); #1;
        rst = 1'b0;
        for (int i = 0; i < 7; i++) dump(vecs[i]);
        repeat (2) @(posedge clk);
        #1;
        check_idle_outputs("final idle");
        $display("== %0d vectors applied, %0d miscompares ==", nvec, nfail);
        $finish;
    end
endmodule
